bit_serializer: RTL
===================

Name: bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 1-1-0-1 sequence detector.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock on w_out, which connects to the detector's w input.
- Asserts bit_valid while a word is being shifted and pulses done on the last bit.
- Supports gap-free back-to-back words, so multi-word patterns reach the detector without idle bits.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = shift out data_in[WIDTH-1] first; 0 = shift out data_in[0] first.
- IDLE_LEVEL, 0: value driven on w_out when no word is being shifted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  valid strobe; requests transfer of data_in.
- ready  output  1  high when a load will be accepted this cycle.
- w_out  output  1  serial bit to the detector's w input.
- bit_valid  output  1  high while w_out carries a data bit.
- done  output  1  one-cycle pulse, coincident with the last bit of a word.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - state = IDLE, shift register = 0, counter = 0.
  - w_out = IDLE_LEVEL, bit_valid = 0, done = 0, ready = 1.
  - Reset asserted mid-word aborts the word immediately; no done pulse is produced and the remaining bits are discarded.
- State machine: two states, IDLE and SHIFT.
- IDLE:
  - ready = 1, bit_valid = 0, w_out = IDLE_LEVEL.
  - load = 1 at a rising edge accepts the word: capture data_in, counter = WIDTH-1, go to SHIFT.
- SHIFT:
  - Latency: the first bit appears on w_out in the cycle after acceptance, with bit_valid = 1.
  - Each edge: shift the register toward the output end, decrement counter, present the next bit.
  - w_out and bit_valid are registered outputs with no combinational path from inputs.
- Last-bit cycle (counter = 0):
  - done = 1 and ready = 1. ready is combinational from state and counter.
  - load = 1 in this cycle: capture the new word, counter = WIDTH-1, stay in SHIFT. The new word's first bit follows the old word's last bit with no gap.
  - load = 0 in this cycle: return to IDLE; w_out = IDLE_LEVEL on the next cycle.
- load while ready = 0 (mid-word):
  - Ignored; no buffering.
  - data_in changes mid-word have no effect on the word being shifted.
- Counter width is $clog2(WIDTH); it never underflows, because the 0 → reload/IDLE decision takes priority.
- done never asserts in IDLE and never asserts twice for one word.
- After reset deassertion, the first accepted load behaves exactly as described for IDLE.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE = 1'b0, SHIFT = 1'b1;
  - the detector pattern constant 4'b1101;
  - a width-of-counter helper macro.
- No sub-module is required. The shift register and down-counter live inline in bit_serializer.
- The top-level integration pairs bit_serializer → sequence detector on a shared clk/reset_n.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with load = 1 → ready = 1, w_out = 0, bit_valid = 0, done = 0 throughout; no word accepted.
- Single word, WIDTH = 4, MSB_FIRST = 1, data_in = 4'b1101, one load pulse → w_out = 1, 1, 0, 1 on cycles 1–4 after acceptance; bit_valid high for exactly those 4 cycles; done only on cycle 4; detector z asserts on the final bit.
- LSB-first, WIDTH = 8, MSB_FIRST = 0, data_in = 8'hA5 → w_out = 1, 0, 1, 0, 0, 1, 0, 1; ready low on cycles 1–7, high on cycle 8.
- Back-to-back, WIDTH = 4, words 4'b0011 then 4'b0100, second load asserted in the last-bit cycle → continuous stream 0, 0, 1, 1, 0, 1, 0, 0 with bit_valid high for 8 contiguous cycles; two done pulses, 4 cycles apart.
- Ignored load: assert load with data_in = 4'b1111 on bit 2 of an in-flight 4'b1000 → stream stays 1, 0, 0, 0; no extra word follows.
- Reset mid-word: drop reset_n during bit 3 of 8'hFF → w_out = 0 and bit_valid = 0 immediately (asynchronously); no done pulse; after release, a new load of 8'h0F shifts correctly.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer feeding the 1-1-0-1 sequence detector.
`ifndef BIT_SERIALIZER_CNT_W
`define BIT_SERIALIZER_CNT_W(w) (((w) <= 2) ? 1 : $clog2(w))
`endif

package bit_serializer_pkg;

    // Two-state serializer control: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Pattern recognised by the downstream detector.
    localparam logic [3:0] DETECT_PATTERN = 4'b1101;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return `BIT_SERIALIZER_CNT_W(width);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage. A word accepted on load/ready is driven one
// bit per clock on w_out, first bit in the cycle after acceptance.
//
// Handshake: a word transfers on a rising edge where load && ready. ready is
// high in IDLE and during the last bit of a word, so a load presented in the
// last-bit cycle continues the stream with no gap. Loads while ready is low are
// dropped, and data_in is only sampled on a transfer.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             w_q,     w_d;
    logic             bv_q,    bv_d;
    logic             last_bit;
    logic             accept;

    // The counter holds the number of bits still to follow the one on w_out.
    assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
    assign ready     = (state_q == IDLE) || last_bit;
    assign done      = last_bit;
    assign accept    = load && ready;
    assign w_out     = w_q;
    assign bit_valid = bv_q;

    // State, shift register, counter and registered serial outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            w_q     <= IDLE_LEVEL;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            bv_q    <= bv_d;
        end
    end

    // Next-state logic: a new word wins over the end-of-word return to IDLE,
    // which in turn wins over a plain shift, so the counter never underflows.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        bv_d    = bv_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = data_in;
            cnt_d   = CNT_LOAD;
            w_d     = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            bv_d    = 1'b1;
        end else if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            w_d     = IDLE_LEVEL;
            bv_d    = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d = cnt_q - 1'b1;
            // shreg still holds the bit on w_out at its output end; present
            // the neighbour and shift it into that position.
            if (MSB_FIRST) begin
                w_d     = shreg_q[WIDTH-2];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                w_d     = shreg_q[1];
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

endmodule
